// File: rtl/thr_scan_if.sv
// UART-side handshake bundle for the threshold-scan controller.
// Ports: rx_byte/rx_dv (gate length strobe), tx_done (byte sent),
//   tx_dv/tx_byte (byte launch). master = UART/host side, slave = controller.
interface thr_scan_if;
   logic [7:0] rx_byte;
   logic       rx_dv;
   logic       tx_done;
   logic       tx_dv;
   logic [7:0] tx_byte;

   modport master (
      output rx_byte, rx_dv, tx_done,
      input  tx_dv, tx_byte
   );

   modport slave (
      input  rx_byte, rx_dv, tx_done,
      output tx_dv, tx_byte
   );
endinterface

// File: rtl/thr_scan_ctrl.sv
// Multi-channel threshold-scan controller: counts discriminator edges for
// a host-set gate, then streams A5 | counts | ovf | xor-checksum over UART.
// Ports: clk, rst (sync, active-low), bus (thr_scan_if.slave),
//   thr_in[N_CH] async inputs, busy (not IDLE), ovf[N_CH] sticky saturation.
module thr_scan_ctrl #(
   parameter int N_CH     = 4,
   parameter int CNT_W    = 32,
   parameter int TICK_DIV = 50000
) (
   input  logic            clk,
   input  logic            rst,
   thr_scan_if.slave       bus,
   input  logic [N_CH-1:0] thr_in,
   output logic            busy,
   output logic [N_CH-1:0] ovf
);
   localparam int BPC  = CNT_W / 8;
   localparam int NB   = N_CH * BPC;
   localparam int LAST = NB + 2;
   localparam int IW   = $clog2(LAST + 1);
   localparam int PW   = $clog2(TICK_DIV + 1);

   typedef enum logic [2:0] {
      IDLE, ARM, GATE, LATCH, SEND_REQ, SEND_WAIT
   } state_t;

   state_t            state, nxt;
   logic [7:0]        gate_len;
   logic [PW-1:0]     pre;
   logic [7:0]        tick;
   logic [N_CH-1:0]   s1, s2, s3;
   logic [N_CH-1:0]   rise;
   logic [CNT_W-1:0]  cnt [N_CH];
   logic [CNT_W-1:0]  shd [N_CH];
   logic [IW-1:0]     idx;
   logic [7:0]        csum;
   logic [7:0]        fbyte;
   logic              pre_wrap;

   assign rise     = s2 & ~s3;
   assign pre_wrap = (pre == PW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   // Leaving on the wrap that makes tick reach gate_len gives exactly
   // gate_len * TICK_DIV cycles in GATE.
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:      if (bus.rx_dv && bus.rx_byte != 8'h00) nxt = ARM;
         ARM:       nxt = GATE;
         GATE:      if (pre_wrap && tick == gate_len - 8'd1) nxt = LATCH;
         LATCH:     nxt = SEND_REQ;
         SEND_REQ:  nxt = SEND_WAIT;
         SEND_WAIT: if (bus.tx_done)
                       nxt = (idx == IW'(LAST)) ? IDLE : SEND_REQ;
         default:   nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.tx_dv   = (state == SEND_REQ);
      bus.tx_byte = (state == SEND_REQ || state == SEND_WAIT) ? fbyte : 8'h00;
      busy        = (state != IDLE);
   end

   always_comb begin
      fbyte = 8'hA5;
      if (idx == IW'(LAST))
         fbyte = csum;
      else if (idx == IW'(NB + 1))
         fbyte = 8'(ovf);
      for (int ch = 0; ch < N_CH; ch++) begin
         for (int j = 0; j < BPC; j++) begin
            if (idx == IW'(1 + ch * BPC + j))
               fbyte = shd[ch][CNT_W - 1 - 8 * j -: 8];
         end
      end
   end

   // Synchroniser runs in every state so a level already high at ARM
   // does not look like a fresh edge once GATE opens.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= thr_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         gate_len <= 8'h00;
         pre      <= '0;
         tick     <= 8'h00;
         ovf      <= '0;
         idx      <= '0;
         csum     <= 8'h00;
         for (int i = 0; i < N_CH; i++) begin
            cnt[i] <= '0;
            shd[i] <= '0;
         end
      end else begin
         if (state == IDLE && nxt == ARM)
            gate_len <= bus.rx_byte;
         if (state == ARM) begin
            pre  <= '0;
            tick <= 8'h00;
            ovf  <= '0;
            for (int i = 0; i < N_CH; i++)
               cnt[i] <= '0;
         end
         if (state == GATE) begin
            pre <= pre_wrap ? '0 : pre + PW'(1);
            if (pre_wrap)
               tick <= tick + 8'd1;
            for (int i = 0; i < N_CH; i++) begin
               if (rise[i]) begin
                  if (&cnt[i]) ovf[i] <= 1'b1;
                  else         cnt[i] <= cnt[i] + CNT_W'(1);
               end
            end
         end
         if (state == LATCH) begin
            idx  <= '0;
            csum <= 8'h00;
            for (int i = 0; i < N_CH; i++)
               shd[i] <= cnt[i];
         end
         // Checksum covers count bytes and the ovf byte, not the header.
         if (state == SEND_REQ && idx != '0 && idx != IW'(LAST))
            csum <= csum ^ fbyte;
         if (state == SEND_WAIT && bus.tx_done && idx != IW'(LAST))
            idx <= idx + IW'(1);
      end
   end
endmodule

// File: tb/tb_thr_scan_ctrl.sv
// Bench for thr_scan_ctrl: a 4ch/32b and a 2ch/8b instance with TICK_DIV=10,
// a TX model answering tx_done 5 cycles after tx_dv, and frame scoreboards.
module tb_thr_scan_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   thr_scan_if ia ();
   thr_scan_if ib ();

   logic [3:0] thr_a;
   logic [1:0] thr_b;
   logic       busy_a, busy_b;
   logic [3:0] ovf_a;
   logic [1:0] ovf_b;

   int checks = 0;
   int fails  = 0;

   logic [7:0] exp_a [$];
   logic [7:0] exp_b [$];
   int         dly_a = 0, dly_b = 0;
   int         dv_cnt_a = 0, dv_cnt_b = 0;
   logic       prev_dv_a = 1'b0, prev_dv_b = 1'b0;
   logic       last_a = 1'b0, last_b = 1'b0;
   logic [7:0] hold_a = 8'h00, hold_b = 8'h00;

   thr_scan_ctrl #(.N_CH(4), .CNT_W(32), .TICK_DIV(10)) dut_a (
      .clk(clk), .rst(rst), .bus(ia), .thr_in(thr_a),
      .busy(busy_a), .ovf(ovf_a)
   );

   thr_scan_ctrl #(.N_CH(2), .CNT_W(8), .TICK_DIV(10)) dut_b (
      .clk(clk), .rst(rst), .bus(ib), .thr_in(thr_b),
      .busy(busy_b), .ovf(ovf_b)
   );

   // TX model and scoreboard for instance a
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         ia.tx_done = 1'b0;
         dly_a = 0;
         last_a = 1'b0;
         exp_a.delete();
      end else begin
         if (ia.tx_done === 1'b1) begin
            ia.tx_done = 1'b0;
            if (last_a) begin
               last_a = 1'b0;
               checks++;
               if (busy_a !== 1'b0) begin
                  fails++;
                  $display("FAIL a_busy_fall: got %0b want 0", busy_a);
               end
            end
         end
         if (dly_a > 0) begin
            checks++;
            if (ia.tx_byte !== hold_a) begin
               fails++;
               $display("FAIL a_byte_hold: got %02h want %02h", ia.tx_byte, hold_a);
            end
            dly_a--;
            if (dly_a == 0) ia.tx_done = 1'b1;
         end
         if (ia.tx_dv === 1'b1) begin
            dv_cnt_a++;
            checks++;
            if (prev_dv_a === 1'b1) begin
               fails++;
               $display("FAIL a_dv_width: got 2+ cycles want 1");
            end
            checks++;
            if (exp_a.size() == 0) begin
               fails++;
               $display("FAIL a_unexpected_dv: got byte %02h want none", ia.tx_byte);
            end else begin
               logic [7:0] e;
               e = exp_a.pop_front();
               if (ia.tx_byte !== e) begin
                  fails++;
                  $display("FAIL a_frame_byte: got %02h want %02h", ia.tx_byte, e);
               end
               if (exp_a.size() == 0) last_a = 1'b1;
            end
            hold_a = ia.tx_byte;
            dly_a = 5;
         end
      end
      prev_dv_a = ia.tx_dv;
   end

   // TX model and scoreboard for instance b
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         ib.tx_done = 1'b0;
         dly_b = 0;
         last_b = 1'b0;
         exp_b.delete();
      end else begin
         if (ib.tx_done === 1'b1) begin
            ib.tx_done = 1'b0;
            if (last_b) begin
               last_b = 1'b0;
               checks++;
               if (busy_b !== 1'b0) begin
                  fails++;
                  $display("FAIL b_busy_fall: got %0b want 0", busy_b);
               end
            end
         end
         if (dly_b > 0) begin
            checks++;
            if (ib.tx_byte !== hold_b) begin
               fails++;
               $display("FAIL b_byte_hold: got %02h want %02h", ib.tx_byte, hold_b);
            end
            dly_b--;
            if (dly_b == 0) ib.tx_done = 1'b1;
         end
         if (ib.tx_dv === 1'b1) begin
            dv_cnt_b++;
            checks++;
            if (prev_dv_b === 1'b1) begin
               fails++;
               $display("FAIL b_dv_width: got 2+ cycles want 1");
            end
            checks++;
            if (exp_b.size() == 0) begin
               fails++;
               $display("FAIL b_unexpected_dv: got byte %02h want none", ib.tx_byte);
            end else begin
               logic [7:0] e;
               e = exp_b.pop_front();
               if (ib.tx_byte !== e) begin
                  fails++;
                  $display("FAIL b_frame_byte: got %02h want %02h", ib.tx_byte, e);
               end
               if (exp_b.size() == 0) last_b = 1'b1;
            end
            hold_b = ib.tx_byte;
            dly_b = 5;
         end
      end
      prev_dv_b = ib.tx_dv;
   end

   task automatic push_frame_a(input int c0, c1, c2, c3, input logic [7:0] ov);
      logic [31:0] c [4];
      logic [7:0]  b, x;
      c[0] = 32'(c0);
      c[1] = 32'(c1);
      c[2] = 32'(c2);
      c[3] = 32'(c3);
      x = 8'h00;
      exp_a.push_back(8'hA5);
      for (int ch = 0; ch < 4; ch++) begin
         for (int j = 3; j >= 0; j--) begin
            b = c[ch][8 * j +: 8];
            exp_a.push_back(b);
            x = x ^ b;
         end
      end
      exp_a.push_back(ov);
      exp_a.push_back(x ^ ov);
   endtask

   task automatic send_rx_a(input logic [7:0] v);
      @(negedge clk);
      ia.rx_byte = v;
      ia.rx_dv = 1'b1;
      @(negedge clk);
      ia.rx_dv = 1'b0;
   endtask

   task automatic send_rx_b(input logic [7:0] v);
      @(negedge clk);
      ib.rx_byte = v;
      ib.rx_dv = 1'b1;
      @(negedge clk);
      ib.rx_dv = 1'b0;
   endtask

   task automatic pulses_a(input int n0, n1, n2, n3);
      int m;
      m = n0;
      if (n1 > m) m = n1;
      if (n2 > m) m = n2;
      if (n3 > m) m = n3;
      for (int i = 0; i < m; i++) begin
         thr_a = {i < n3, i < n2, i < n1, i < n0};
         repeat (2) @(negedge clk);
         thr_a = 4'h0;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic pulses_b(input int n0, n1);
      int m;
      m = (n0 > n1) ? n0 : n1;
      for (int i = 0; i < m; i++) begin
         thr_b = {i < n1, i < n0};
         repeat (2) @(negedge clk);
         thr_b = 2'b00;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic wait_dv_a(output int k);
      k = 0;
      while (ia.tx_dv !== 1'b1 && k < 5000) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic wait_dv_b(output int k);
      k = 0;
      while (ib.tx_dv !== 1'b1 && k < 5000) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic wait_idle_a(input string nm);
      int k;
      k = 0;
      while ((exp_a.size() != 0 || busy_a !== 1'b0) && k < 5000) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k >= 5000) begin
         fails++;
         $display("FAIL %s_timeout: got %0d bytes left want 0", nm, exp_a.size());
      end
   endtask

   task automatic wait_idle_b(input string nm);
      int k;
      k = 0;
      while ((exp_b.size() != 0 || busy_b !== 1'b0) && k < 5000) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k >= 5000) begin
         fails++;
         $display("FAIL %s_timeout: got %0d bytes left want 0", nm, exp_b.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      ia.rx_dv = 1'b0;
      ia.rx_byte = 8'h00;
      ib.rx_dv = 1'b0;
      ib.rx_byte = 8'h00;
      thr_a = 4'h0;
      thr_b = 2'b00;
      repeat (3) @(negedge clk);
      checks++;
      if ({ia.tx_dv, ia.tx_byte, busy_a, ovf_a} !== 14'h0) begin
         fails++;
         $display("FAIL reset_a: got dv=%b byte=%02h busy=%b ovf=%h want 0",
                  ia.tx_dv, ia.tx_byte, busy_a, ovf_a);
      end
      checks++;
      if ({ib.tx_dv, ib.tx_byte, busy_b, ovf_b} !== 12'h0) begin
         fails++;
         $display("FAIL reset_b: got dv=%b byte=%02h busy=%b ovf=%h want 0",
                  ib.tx_dv, ib.tx_byte, busy_b, ovf_b);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic_frame();
      int k, n;
      n = dv_cnt_a;
      push_frame_a(7, 0, 3, 1, 8'h00);
      send_rx_a(8'd5);
      checks++;
      if (busy_a !== 1'b1) begin
         fails++;
         $display("FAIL busy_rise: got %0b want 1", busy_a);
      end
      fork
         pulses_a(7, 0, 3, 1);
         wait_dv_a(k);
      join
      checks++;
      if (k != 52) begin
         fails++;
         $display("FAIL gate_len_5: got %0d want 52 cycles to first tx_dv", k);
      end
      wait_idle_a("basic");
      checks++;
      if (dv_cnt_a - n != 19) begin
         fails++;
         $display("FAIL basic_len: got %0d want 19", dv_cnt_a - n);
      end
      checks++;
      if (ovf_a !== 4'h0) begin
         fails++;
         $display("FAIL basic_ovf: got %h want 0", ovf_a);
      end
   endtask

   task automatic test_saturation();
      int k;
      exp_b.push_back(8'hA5);
      exp_b.push_back(8'hFF);
      exp_b.push_back(8'h02);
      exp_b.push_back(8'h01);
      exp_b.push_back(8'hFC);
      send_rx_b(8'd200);
      fork
         pulses_b(300, 2);
         wait_dv_b(k);
      join
      checks++;
      if (k != 2002) begin
         fails++;
         $display("FAIL sat_gate: got %0d want 2002 cycles to first tx_dv", k);
      end
      wait_idle_b("sat");
      checks++;
      if (ovf_b !== 2'b01) begin
         fails++;
         $display("FAIL sat_ovf: got %b want 01", ovf_b);
      end
   endtask

   task automatic test_zero_and_busy_rx();
      int k, n;
      n = dv_cnt_a;
      send_rx_a(8'd0);
      checks++;
      if (busy_a !== 1'b0) begin
         fails++;
         $display("FAIL zero_busy: got %0b want 0", busy_a);
      end
      repeat (30) @(negedge clk);
      checks++;
      if (busy_a !== 1'b0 || dv_cnt_a != n) begin
         fails++;
         $display("FAIL zero_idle: got busy=%0b dv=%0d want busy=0 dv=0",
                  busy_a, dv_cnt_a - n);
      end
      push_frame_a(0, 0, 0, 0, 8'h00);
      send_rx_a(8'd3);
      repeat (5) @(negedge clk);
      send_rx_a(8'd100);
      wait_dv_a(k);
      checks++;
      if (k != 25) begin
         fails++;
         $display("FAIL rx_in_gate: got %0d want 25 cycles to first tx_dv", k);
      end
      wait_idle_a("rx_in_gate");
      repeat (60) @(negedge clk);
      checks++;
      if (dv_cnt_a - n != 19) begin
         fails++;
         $display("FAIL one_frame: got %0d want 19 tx_dv", dv_cnt_a - n);
      end
   endtask

   task automatic test_gate_boundary();
      push_frame_a(1, 0, 0, 0, 8'h00);
      send_rx_a(8'd1);
      repeat (8) @(negedge clk);
      thr_a[0] = 1'b1;
      @(negedge clk);
      thr_a[1] = 1'b1;
      @(negedge clk);
      thr_a[0] = 1'b0;
      @(negedge clk);
      thr_a[1] = 1'b0;
      wait_idle_a("boundary");
   endtask

   task automatic test_reset_mid_frame();
      int k, n;
      n = dv_cnt_a;
      push_frame_a(0, 2, 0, 1, 8'h00);
      send_rx_a(8'd2);
      pulses_a(0, 2, 0, 1);
      k = 0;
      while (dv_cnt_a < n + 4 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (dv_cnt_a != n + 4) begin
         fails++;
         $display("FAIL mid_reach4: got %0d want 4 tx_dv", dv_cnt_a - n);
      end
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({ia.tx_dv, ia.tx_byte, busy_a, ovf_a} !== 14'h0) begin
         fails++;
         $display("FAIL mid_reset_out: got dv=%b byte=%02h busy=%b ovf=%h want 0",
                  ia.tx_dv, ia.tx_byte, busy_a, ovf_a);
      end
      repeat (40) @(negedge clk);
      checks++;
      if (dv_cnt_a != n + 4) begin
         fails++;
         $display("FAIL mid_no_dv: got %0d want 4 tx_dv", dv_cnt_a - n);
      end
      n = dv_cnt_a;
      push_frame_a(5, 1, 0, 2, 8'h00);
      send_rx_a(8'd4);
      fork
         pulses_a(5, 1, 0, 2);
         wait_dv_a(k);
      join
      checks++;
      if (k != 42) begin
         fails++;
         $display("FAIL post_reset_gate: got %0d want 42", k);
      end
      wait_idle_a("post_reset");
      checks++;
      if (dv_cnt_a - n != 19) begin
         fails++;
         $display("FAIL post_reset_len: got %0d want 19", dv_cnt_a - n);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_frame();
      test_saturation();
      test_zero_and_busy_rx();
      test_gate_boundary();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
